calc_engine: RTL and testbench
==============================

Name: calc_engine

Overview:
- Parametrised calculator execution engine: opcode decode, control FSM, iterative shift-add multiplier and accumulator in one block.
- Successor to the fixed-width controller/counter/decoder trio, generalised in operand width.
- Adds over that trio: valid/ready command handshake, load/clear/illegal-opcode handling, per-result and sticky overflow flags.
- Sits between the command front-end and the result/display path.

Parameters:
- WIDTH, 8, operand/accumulator width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), derived localparam, multiply iteration counter width (not overridable).

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  command present.
- op_ready  out  1  engine can accept a command.
- op_code  in  3  000 LOAD, 001 ADD, 010 SUB, 011 MUL, 100 CLR, 101-111 illegal.
- op_data  in  WIDTH  operand B.
- res_valid  out  1  one-cycle result pulse; no backpressure.
- res_data  out  WIDTH  accumulator value after the operation.
- res_ovf  out  1  overflow of this operation; qualified by res_valid.
- res_err  out  1  illegal opcode; qualified by res_valid.
- ovf_sticky  out  1  OR of all res_ovf since reset or last CLR.
- busy  out  1  multiply in progress (== ~op_ready).

Behaviour:
- Reset (async, any state): FSM->S_IDLE, acc=0, counter=0, res_valid=0, res_data=0, res_ovf=0, res_err=0, ovf_sticky=0, busy=0. op_ready=1 from the first cycle after Rst deasserts.
- Accept: command accepted on a rising edge where op_valid && op_ready. op_valid while op_ready=0 is ignored; the source must hold it.
- FSM states: S_IDLE, S_MUL.
- In S_IDLE, single-cycle ops (LOAD/ADD/SUB/CLR/illegal) are executed at the accept edge. FSM stays in S_IDLE, so throughput is 1 op/cycle. res_valid is high in the following cycle.
- LOAD: acc=op_data, ovf=0.
- ADD: acc=(acc+op_data) mod 2^WIDTH, ovf=carry out (unsigned).
- SUB: acc=(acc-op_data) mod 2^WIDTH, ovf=borrow (op_data>acc).
- CLR: acc=0, ovf=0, ovf_sticky cleared at the same edge.
- Illegal opcode: acc unchanged, res_err=1, ovf=0.
- MUL at accept edge E0:
  - Latch multiplicand=acc (zero-extended to 2*WIDTH), multiplier=op_data, product=0, counter=WIDTH.
  - FSM->S_MUL; op_ready=0 and busy=1 from the next cycle.
- MUL iteration on each edge in S_MUL:
  - If multiplier[0], product+=multiplicand.
  - Multiplicand<<=1, multiplier>>=1, counter-=1.
- MUL completion: at edge E0+WIDTH (counter 1->0), acc=product[WIDTH-1:0], ovf=|product[2W-1:WIDTH], FSM->S_IDLE. res_valid is high in the cycle after E0+WIDTH, the same cycle op_ready returns to 1.
- MUL has fixed latency WIDTH edges; no early termination.
- res_valid is 0 in every cycle not following a completion. res_data/res_ovf/res_err hold their last values when res_valid=0.
- ovf_sticky is set on the edge producing a result with ovf=1. CLR clear takes priority over set (CLR never overflows).
- Reset mid-multiply: abort immediately, no res_valid, acc=0.
- Boundaries:
  - ADD of all-ones+1 -> 0, ovf=1.
  - SUB equal operands -> 0, ovf=0.
  - MUL by 0 -> 0 after WIDTH cycles, ovf=0.
  - MUL of max*max -> low bits 1, ovf=1.

Decomposition:
- Package calc_pkg: opcode constants (OP_LOAD..OP_CLR), FSM state encoding (S_IDLE, S_MUL), function returning CNT_W from WIDTH.
- Sub-module calc_mul_seq (parameter WIDTH): shift-add multiplier with start/done and iteration counter, holding its 2*WIDTH product. The top keeps the FSM, accumulator, flags and handshake.

Test Plan (WIDTH=8):
- Reset: assert Rst mid-stream -> all outputs 0 immediately; op_ready=1 one cycle after release; res_valid stays 0.
- Back-to-back arithmetic: LOAD 200, ADD 100 on consecutive cycles -> res 200/ovf0, then res 44/ovf1, ovf_sticky=1.
- Subtract borrow: LOAD 5, SUB 7 -> res 254/ovf1. Follow with SUB 254 -> res 0/ovf0, ovf_sticky stays 1.
- Multiply: LOAD 13, MUL 11 -> op_ready low 8 cycles, res 143/ovf0 in the cycle after accept edge+8.
- Multiply overflow with held command: LOAD 20, MUL 20 -> res 144/ovf1. ADD 1 presented with op_valid during busy -> accepted only after completion, res 145.
- Illegal op and clear: op_code 110 -> res_err1, acc unchanged. CLR -> res 0, ovf_sticky 0. Rst at MUL iteration 4 -> no result, acc 0, op_ready 1 after release.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcode constants, FSM encoding and width helper for the calculator engine.
package calc_pkg;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    // Bits needed to count down from w to 0.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per clock, fixed WIDTH steps.
module calc_mul_seq
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last_c,
    output logic [2*WIDTH-1:0]   prod_next_c
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    logic [PW-1:0]    mcand;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    // Product after the step taken at the coming edge; the final step's value is the result.
    assign prod_next_c = mplier[0] ? (prod + mcand) : prod;
    assign last_c      = (cnt == CNT_W'(1));

    // Operand latch on start, then shift-add until the counter reaches zero.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mcand  <= '0;
            prod   <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            prod   <= '0;
            mplier <= b;
            cnt    <= CNT_W'(WIDTH);
        end else if (cnt != '0) begin
            prod   <= prod_next_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/calc_engine.sv
// Calculator execution engine: command handshake, accumulator, overflow flags, multiply control.
module calc_engine
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_data,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             res_err,
    output logic             ovf_sticky,
    output logic             busy
);

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH-1:0]   alu_acc_c;
    logic               alu_ovf_c;
    logic               alu_err_c;
    logic               accept_c;
    logic               mul_start_c;
    logic               mul_last_c;
    logic [2*WIDTH-1:0] mul_prod_c;
    logic               mul_ovf_c;

    assign accept_c    = (state == S_IDLE) && op_valid && op_ready;
    assign mul_start_c = accept_c && (op_code == OP_MUL);
    assign sum_c       = {1'b0, acc} + {1'b0, op_data};
    assign mul_ovf_c   = |mul_prod_c[2*WIDTH-1:WIDTH];

    // Single-cycle operation result for the command currently presented.
    always_comb begin
        alu_acc_c = acc;
        alu_ovf_c = 1'b0;
        alu_err_c = 1'b0;
        case (op_code)
            OP_LOAD: alu_acc_c = op_data;
            OP_ADD: begin
                alu_acc_c = sum_c[WIDTH-1:0];
                alu_ovf_c = sum_c[WIDTH];
            end
            OP_SUB: begin
                alu_acc_c = acc - op_data;
                alu_ovf_c = (op_data > acc);
            end
            OP_MUL:  alu_acc_c = acc;
            OP_CLR:  alu_acc_c = '0;
            default: alu_err_c = 1'b1;
        endcase
    end

    calc_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .Clk         (Clk),
        .Rst         (Rst),
        .start       (mul_start_c),
        .a           (acc),
        .b           (op_data),
        .last_c      (mul_last_c),
        .prod_next_c (mul_prod_c)
    );

    // Control FSM with accumulator, result registers and sticky overflow.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            op_ready   <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_ovf    <= 1'b0;
            res_err    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    op_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (mul_start_c) begin
                        state    <= S_MUL;
                        op_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else if (accept_c) begin
                        acc       <= alu_acc_c;
                        res_valid <= 1'b1;
                        res_data  <= alu_acc_c;
                        res_ovf   <= alu_ovf_c;
                        res_err   <= alu_err_c;
                        if (op_code == OP_CLR) begin
                            ovf_sticky <= 1'b0;
                        end else if (alu_ovf_c) begin
                            ovf_sticky <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_last_c) begin
                        state      <= S_IDLE;
                        op_ready   <= 1'b1;
                        busy       <= 1'b0;
                        acc        <= mul_prod_c[WIDTH-1:0];
                        res_valid  <= 1'b1;
                        res_data   <= mul_prod_c[WIDTH-1:0];
                        res_ovf    <= mul_ovf_c;
                        res_err    <= 1'b0;
                        if (mul_ovf_c) begin
                            ovf_sticky <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_engine.sv
// Directed self-checking bench for calc_engine at WIDTH=8.
module tb_calc_engine;
    import calc_pkg::*;

    logic       Clk;
    logic       Rst;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [7:0] op_data;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ovf;
    logic       res_err;
    logic       ovf_sticky;
    logic       busy;

    int tests;
    int fails;

    calc_engine #(.WIDTH(8)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_data    (op_data),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ovf    (res_ovf),
        .res_err    (res_err),
        .ovf_sticky (ovf_sticky),
        .busy       (busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Present one command for exactly one edge; returns #1 after that edge.
    task automatic issue(input logic [2:0] code, input logic [7:0] data);
        @(negedge Clk);
        op_code  = code;
        op_data  = data;
        op_valid = 1'b1;
        @(posedge Clk);
        #1;
        op_valid = 1'b0;
    endtask

    // Start a multiply and wait (bounded) for op_ready to return.
    task automatic do_mul(input logic [7:0] data, output int cycles, output int early);
        issue(OP_MUL, data);
        cycles = 0;
        early  = 0;
        while (!op_ready && cycles < 20) begin
            if (res_valid) early++;
            @(posedge Clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0; op_valid = 1'b0; op_code = '0; op_data = '0;
        #2 Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        tests++; if (op_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: ready=%0b busy=%0b valid=%0b, want 0/0/0", op_ready, busy, res_valid); end
        @(negedge Clk); Rst = 1'b0;
        @(posedge Clk); #1;
        tests++; if (op_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: op_ready=%0b want 1", op_ready); end
        // Mid-stream reset: outputs must clear without waiting for a clock.
        issue(OP_LOAD, 8'd77);
        tests++; if (res_valid !== 1'b1 || res_data !== 8'd77) begin
            fails++; $display("FAIL pre_reset_load: valid=%0b data=%0d want 1/77", res_valid, res_data); end
        @(negedge Clk); #2 Rst = 1'b1; #1;
        tests++; if (res_valid !== 1'b0 || res_data !== 8'd0 || res_ovf !== 1'b0 || res_err !== 1'b0
                     || ovf_sticky !== 1'b0 || op_ready !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_async: valid=%0b data=%0d ovf=%0b err=%0b sticky=%0b ready=%0b busy=%0b want all 0",
                              res_valid, res_data, res_ovf, res_err, ovf_sticky, op_ready, busy); end
        @(negedge Clk); Rst = 1'b0;
        @(posedge Clk); #1;
        tests++; if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
            fails++; $display("FAIL reset_release: ready=%0b valid=%0b want 1/0", op_ready, res_valid); end
    endtask

    task automatic test_back_to_back();
        issue(OP_LOAD, 8'd200);
        tests++; if (res_valid !== 1'b1 || res_data !== 8'd200 || res_ovf !== 1'b0) begin
            fails++; $display("FAIL load200: valid=%0b data=%0d ovf=%0b want 1/200/0", res_valid, res_data, res_ovf); end
        issue(OP_ADD, 8'd100);
        tests++; if (res_valid !== 1'b1 || res_data !== 8'd44 || res_ovf !== 1'b1 || ovf_sticky !== 1'b1) begin
            fails++; $display("FAIL add100: valid=%0b data=%0d ovf=%0b sticky=%0b want 1/44/1/1", res_valid, res_data, res_ovf, ovf_sticky); end
        @(posedge Clk); #1;
        tests++; if (res_valid !== 1'b0 || res_data !== 8'd44) begin
            fails++; $display("FAIL idle_hold: valid=%0b data=%0d want 0/44", res_valid, res_data); end
        issue(OP_LOAD, 8'd255);
        issue(OP_ADD, 8'd1);
        tests++; if (res_data !== 8'd0 || res_ovf !== 1'b1) begin
            fails++; $display("FAIL add_wrap: data=%0d ovf=%0b want 0/1", res_data, res_ovf); end
    endtask

    task automatic test_sub();
        issue(OP_LOAD, 8'd5);
        issue(OP_SUB, 8'd7);
        tests++; if (res_valid !== 1'b1 || res_data !== 8'd254 || res_ovf !== 1'b1) begin
            fails++; $display("FAIL sub_borrow: valid=%0b data=%0d ovf=%0b want 1/254/1", res_valid, res_data, res_ovf); end
        issue(OP_SUB, 8'd254);
        tests++; if (res_data !== 8'd0 || res_ovf !== 1'b0 || ovf_sticky !== 1'b1) begin
            fails++; $display("FAIL sub_equal: data=%0d ovf=%0b sticky=%0b want 0/0/1", res_data, res_ovf, ovf_sticky); end
    endtask

    task automatic test_mul();
        int cyc;
        int early;
        issue(OP_LOAD, 8'd13);
        do_mul(8'd11, cyc, early);
        tests++; if (cyc !== 8 || early !== 0) begin
            fails++; $display("FAIL mul_latency: busy cycles=%0d early_valid=%0d want 8/0", cyc, early); end
        tests++; if (res_valid !== 1'b1 || res_data !== 8'd143 || res_ovf !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL mul_13x11: valid=%0b data=%0d ovf=%0b busy=%0b want 1/143/0/0", res_valid, res_data, res_ovf, busy); end
        issue(OP_LOAD, 8'd9);
        do_mul(8'd0, cyc, early);
        tests++; if (cyc !== 8 || res_valid !== 1'b1 || res_data !== 8'd0 || res_ovf !== 1'b0) begin
            fails++; $display("FAIL mul_zero: cycles=%0d valid=%0b data=%0d ovf=%0b want 8/1/0/0", cyc, res_valid, res_data, res_ovf); end
        issue(OP_LOAD, 8'd255);
        do_mul(8'd255, cyc, early);
        tests++; if (res_valid !== 1'b1 || res_data !== 8'd1 || res_ovf !== 1'b1) begin
            fails++; $display("FAIL mul_max: valid=%0b data=%0d ovf=%0b want 1/1/1", res_valid, res_data, res_ovf); end
    endtask

    task automatic test_mul_hold();
        int cyc;
        issue(OP_LOAD, 8'd20);
        issue(OP_MUL, 8'd20);
        tests++; if (op_ready !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL mul_busy: ready=%0b busy=%0b want 0/1", op_ready, busy); end
        op_code = OP_ADD; op_data = 8'd1; op_valid = 1'b1;
        cyc = 0;
        while (!op_ready && cyc < 20) begin
            @(posedge Clk); #1; cyc++;
        end
        tests++; if (cyc !== 8 || res_valid !== 1'b1 || res_data !== 8'd144 || res_ovf !== 1'b1) begin
            fails++; $display("FAIL mul_20x20: cycles=%0d valid=%0b data=%0d ovf=%0b want 8/1/144/1", cyc, res_valid, res_data, res_ovf); end
        @(posedge Clk); #1;
        op_valid = 1'b0;
        tests++; if (res_valid !== 1'b1 || res_data !== 8'd145 || res_ovf !== 1'b0) begin
            fails++; $display("FAIL held_add: valid=%0b data=%0d ovf=%0b want 1/145/0", res_valid, res_data, res_ovf); end
    endtask

    task automatic test_illegal_clr();
        int stray;
        issue(3'b110, 8'd33);
        tests++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 8'd145 || res_ovf !== 1'b0) begin
            fails++; $display("FAIL illegal: valid=%0b err=%0b data=%0d ovf=%0b want 1/1/145/0", res_valid, res_err, res_data, res_ovf); end
        issue(OP_CLR, 8'd99);
        tests++; if (res_data !== 8'd0 || res_err !== 1'b0 || ovf_sticky !== 1'b0) begin
            fails++; $display("FAIL clr: data=%0d err=%0b sticky=%0b want 0/0/0", res_data, res_err, ovf_sticky); end
        // Reset during multiply iteration 4.
        issue(OP_LOAD, 8'd50);
        issue(OP_MUL, 8'd3);
        repeat (4) @(posedge Clk);
        @(negedge Clk); #1 Rst = 1'b1; #1;
        tests++; if (op_ready !== 1'b0 || busy !== 1'b0 || res_data !== 8'd0) begin
            fails++; $display("FAIL mul_abort: ready=%0b busy=%0b data=%0d want 0/0/0", op_ready, busy, res_data); end
        repeat (2) @(posedge Clk);
        @(negedge Clk); Rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            if (res_valid) stray++;
        end
        tests++; if (op_ready !== 1'b1 || stray !== 0) begin
            fails++; $display("FAIL abort_release: ready=%0b stray_valid=%0d want 1/0", op_ready, stray); end
        issue(OP_ADD, 8'd0);
        tests++; if (res_valid !== 1'b1 || res_data !== 8'd0 || res_ovf !== 1'b0) begin
            fails++; $display("FAIL acc_cleared: valid=%0b data=%0d ovf=%0b want 1/0/0", res_valid, res_data, res_ovf); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_back_to_back();
        test_sub();
        test_mul();
        test_mul_hold();
        test_illegal_clr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
